lsu_mem_port: RTL and testbench



---
 rtl/lsu_mem_port.sv | 226 ++++++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store unit: issues one valid/ready bus transaction per decoded
// load/store, stalls the core until the response, and returns an aligned,
// extended load result. Misaligned and illegal accesses never reach the bus.
// Optional build macro LSU_TIMEOUT_EN adds a response-wait timeout.
//
// state  | meaning
// IDLE   | waiting for req_valid; request is latched here
// REQ    | bus_req_valid high until the bus accepts
// RESP   | waiting for bus_rsp_valid
// DONE   | one-cycle completion; core commits, fault/result valid
module lsu_mem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic        misalign,
    output logic [31:0] mem_data_out,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    input  logic        bus_rsp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        fault_q, fault_d;
    logic        misalign_q, misalign_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_illegal, req_misalign;
    logic        tmo;
    logic [1:0]  off;
    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;
    logic [31:0] load_val;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;

    assign off = addr_q[1:0];

    // Classify the incoming request before it is latched
    always_comb begin
        req_illegal  = 1'b0;
        req_misalign = 1'b0;
        if (req_is_store) begin
            req_illegal = (funct3 >= 3'd3);
        end else begin
            req_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        if (!req_illegal) begin
            case (funct3[1:0])
                2'b01:   req_misalign = addr[0];
                2'b10:   req_misalign = (addr[1:0] != 2'b00);
                default: req_misalign = 1'b0;
            endcase
        end
    end

    // Extract and extend the addressed byte/halfword from the read word
    always_comb begin
        case (off)
            2'd0:    rsp_byte = bus_rsp_rdata[7:0];
            2'd1:    rsp_byte = bus_rsp_rdata[15:8];
            2'd2:    rsp_byte = bus_rsp_rdata[23:16];
            default: rsp_byte = bus_rsp_rdata[31:24];
        endcase
        rsp_half = off[1] ? bus_rsp_rdata[31:16] : bus_rsp_rdata[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{rsp_byte[7]}}, rsp_byte};
            3'b100:  load_val = {24'd0, rsp_byte};
            3'b001:  load_val = {{16{rsp_half[15]}}, rsp_half};
            3'b101:  load_val = {16'd0, rsp_half};
            default: load_val = bus_rsp_rdata;
        endcase
    end

    // Store byte-lane strobes and replicated write data
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << off;
                st_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_strb  = 4'b0011 << off;
                st_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = wdata_q;
            end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Cycle counter for REQ/RESP; cleared on entry to REQ
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if ((state_q == S_REQ) || (state_q == S_RESP)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Timeout counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign tmo = 1'b0;
`endif

    // Transaction FSM; fault/result registers are only non-zero in DONE
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        fault_d    = 1'b0;
        misalign_d = 1'b0;
        rdata_d    = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    is_store_d = req_is_store;
                    funct3_d   = funct3;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    if (req_illegal || req_misalign) begin
                        state_d    = S_DONE;
                        fault_d    = 1'b1;
                        misalign_d = req_misalign;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (tmo) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                end else if (bus_req_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus_rsp_valid) begin
                    state_d = S_DONE;
                    fault_d = bus_rsp_err;
                    rdata_d = (bus_rsp_err || is_store_q) ? 32'd0 : load_val;
                end else if (tmo) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched-request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            fault_q    <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            fault_q    <= fault_d;
            misalign_q <= misalign_d;
            rdata_q    <= rdata_d;
        end
    end

    assign stall         = ((state_q == S_IDLE) && req_valid) || (state_q == S_REQ) || (state_q == S_RESP);
    assign done          = (state_q == S_DONE);
    assign fault         = fault_q;
    assign misalign      = misalign_q;
    assign mem_data_out  = rdata_q;
    assign bus_req_valid = (state_q == S_REQ);
    assign bus_addr      = bus_req_valid ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_we        = bus_req_valid & is_store_q;
    assign bus_wstrb     = (bus_req_valid && is_store_q) ? st_strb : 4'd0;
    assign bus_wdata     = (bus_req_valid && is_store_q) ? st_wdata : 32'd0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a small reactive bus model.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, fault, misalign;
    logic [31:0] mem_data_out;
    logic        bus_req_valid, bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    int          r_stall, r_breq;
    logic        r_done, r_fault, r_mis, r_stall_done, r_bwe;
    logic [31:0] r_dout, r_baddr, r_bwdata;
    logic [3:0]  r_strb;

    always #5 clk = ~clk;

    lsu_mem_port #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_is_store(req_is_store), .funct3(funct3),
        .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .fault(fault), .misalign(misalign),
        .mem_data_out(mem_data_out),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction; bus accepts after rdy_dly REQ cycles, responds the cycle after.
    task automatic do_txn(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int rdy_dly,
                          input logic [31:0] rd, input logic err);
        logic acc_prev;
        int   waited;
        acc_prev = 1'b0;
        waited   = 0;
        r_stall = 0; r_breq = 0; r_done = 1'b0; r_fault = 1'b0; r_mis = 1'b0;
        r_stall_done = 1'b0; r_bwe = 1'b0; r_dout = 32'd0; r_baddr = 32'd0;
        r_bwdata = 32'd0; r_strb = 4'd0;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; funct3 = f3; addr = a; wdata = wd;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (done) begin
                r_done = 1'b1; r_fault = fault; r_mis = misalign;
                r_dout = mem_data_out; r_stall_done = stall;
                break;
            end
            if (stall) r_stall++;
            bus_rsp_valid = acc_prev;
            bus_rsp_rdata = acc_prev ? rd : 32'd0;
            bus_rsp_err   = acc_prev & err;
            if (bus_req_valid) begin
                r_breq++;
                r_baddr = bus_addr; r_bwe = bus_we; r_strb = bus_wstrb; r_bwdata = bus_wdata;
                bus_req_ready = (waited >= rdy_dly);
                waited++;
            end else begin
                bus_req_ready = 1'b0;
            end
            acc_prev = bus_req_valid & bus_req_ready;
            @(negedge clk);
        end
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; bus_rsp_rdata = 32'd0;
        req_valid = 1'b0;
        chk_val({tag, "_done_seen"}, 32'(r_done), 32'd1);
        chk_val({tag, "_stall_in_done"}, 32'(r_stall_done), 32'd0);
        @(negedge clk);
        #1;
        chk_val({tag, "_done_pulse"}, {30'd0, done, fault}, 32'd0);
    endtask

    task automatic exp_txn(input string tag, input int e_stall, input int e_breq,
                           input logic e_fault, input logic e_mis, input logic [31:0] e_dout);
        chk_val({tag, "_stall_cycles"}, 32'(r_stall), 32'(e_stall));
        chk_val({tag, "_breq_cycles"}, 32'(r_breq), 32'(e_breq));
        chk_val({tag, "_fault"}, 32'(r_fault), 32'(e_fault));
        chk_val({tag, "_misalign"}, 32'(r_mis), 32'(e_mis));
        chk_val({tag, "_dout"}, r_dout, e_dout);
    endtask

    task automatic exp_bus(input string tag, input logic [31:0] e_addr, input logic e_we,
                           input logic [3:0] e_strb, input logic [31:0] e_wdata);
        chk_val({tag, "_bus_addr"}, r_baddr, e_addr);
        chk_val({tag, "_bus_we"}, 32'(r_bwe), 32'(e_we));
        chk_val({tag, "_bus_wstrb"}, 32'(r_strb), 32'(e_strb));
        chk_val({tag, "_bus_wdata"}, r_bwdata, e_wdata);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        bus_rsp_rdata = 32'd0; bus_rsp_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_val("rst_ctrl", {27'd0, stall, done, fault, misalign, bus_req_valid}, 32'd0);
        chk_val("rst_dout", mem_data_out, 32'd0);
        chk_val("rst_bus", {27'd0, bus_we, bus_wstrb}, 32'd0);
        chk_val("rst_bus_addr", bus_addr, 32'd0);
        rst = 1'b0;

        do_txn("lw", 1'b0, 3'b010, 32'h8000_0104, 32'd0, 0, 32'hDEAD_BEEF, 1'b0);
        exp_txn("lw", 3, 1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        exp_bus("lw", 32'h8000_0104, 1'b0, 4'b0000, 32'd0);

        do_txn("lb", 1'b0, 3'b000, 32'h8000_0107, 32'd0, 0, 32'h8011_2233, 1'b0);
        exp_txn("lb", 3, 1, 1'b0, 1'b0, 32'hFFFF_FF80);
        chk_val("lb_bus_addr", r_baddr, 32'h8000_0104);
        do_txn("lbu", 1'b0, 3'b100, 32'h8000_0107, 32'd0, 0, 32'h8011_2233, 1'b0);
        exp_txn("lbu", 3, 1, 1'b0, 1'b0, 32'h0000_0080);
        do_txn("lb_pos", 1'b0, 3'b000, 32'h8000_0105, 32'd0, 0, 32'h8011_2233, 1'b0);
        exp_txn("lb_pos", 3, 1, 1'b0, 1'b0, 32'h0000_0022);
        do_txn("lhu", 1'b0, 3'b101, 32'h8000_0102, 32'd0, 0, 32'h8011_2233, 1'b0);
        exp_txn("lhu", 3, 1, 1'b0, 1'b0, 32'h0000_8011);
        do_txn("lh", 1'b0, 3'b001, 32'h8000_0102, 32'd0, 0, 32'h8011_2233, 1'b0);
        exp_txn("lh", 3, 1, 1'b0, 1'b0, 32'hFFFF_8011);
        do_txn("lh_lo", 1'b0, 3'b001, 32'h8000_0100, 32'd0, 0, 32'h8011_2233, 1'b0);
        exp_txn("lh_lo", 3, 1, 1'b0, 1'b0, 32'h0000_2233);

        do_txn("sh", 1'b1, 3'b001, 32'h8000_0102, 32'h1234_ABCD, 0, 32'hFFFF_FFFF, 1'b0);
        exp_txn("sh", 3, 1, 1'b0, 1'b0, 32'd0);
        exp_bus("sh", 32'h8000_0100, 1'b1, 4'b1100, 32'hABCD_ABCD);
        do_txn("sb", 1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 0, 32'hFFFF_FFFF, 1'b0);
        exp_txn("sb", 3, 1, 1'b0, 1'b0, 32'd0);
        exp_bus("sb", 32'h0000_0010, 1'b1, 4'b0010, 32'hA5A5_A5A5);
        do_txn("sw", 1'b1, 3'b010, 32'h0000_0020, 32'h1122_3344, 0, 32'hFFFF_FFFF, 1'b0);
        exp_bus("sw", 32'h0000_0020, 1'b1, 4'b1111, 32'h1122_3344);

        do_txn("lw_mis", 1'b0, 3'b010, 32'h8000_0102, 32'd0, 0, 32'h1234_5678, 1'b0);
        exp_txn("lw_mis", 1, 0, 1'b1, 1'b1, 32'd0);
        do_txn("sh_mis", 1'b1, 3'b001, 32'h8000_0103, 32'h5555_5555, 0, 32'd0, 1'b0);
        exp_txn("sh_mis", 1, 0, 1'b1, 1'b1, 32'd0);
        do_txn("ld_ill", 1'b0, 3'b011, 32'h8000_0100, 32'd0, 0, 32'h1234_5678, 1'b0);
        exp_txn("ld_ill", 1, 0, 1'b1, 1'b0, 32'd0);
        do_txn("st_ill", 1'b1, 3'b100, 32'h8000_0100, 32'd0, 0, 32'd0, 1'b0);
        exp_txn("st_ill", 1, 0, 1'b1, 1'b0, 32'd0);

        do_txn("err", 1'b0, 3'b010, 32'h8000_0200, 32'd0, 4, 32'hCAFE_F00D, 1'b1);
        exp_txn("err", 7, 5, 1'b1, 1'b0, 32'd0);

        // Stray response while idle must not complete anything
        @(negedge clk);
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h1111_1111;
        @(negedge clk);
        #1;
        chk_val("stray_rsp", {30'd0, done, stall}, 32'd0);
        bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'd0;

        // Reset while waiting in RESP
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; funct3 = 3'b010; addr = 32'h8000_0300;
        @(negedge clk);
        bus_req_ready = 1'b1;
        #1;
        chk_val("rst_mid_req", 32'(bus_req_valid), 32'd1);
        @(negedge clk);
        bus_req_ready = 1'b0;
        #1;
        chk_val("rst_mid_resp_stall", 32'(stall), 32'd1);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk_val("rst_mid_ctrl", {27'd0, stall, done, fault, misalign, bus_req_valid}, 32'd0);
        chk_val("rst_mid_bus", bus_addr | mem_data_out | bus_wdata | {27'd0, bus_we, bus_wstrb}, 32'd0);
        rst = 1'b0;

`ifdef LSU_TIMEOUT_EN
        begin
            int   since_req;
            logic seen_req, seen_done;
            since_req = 0; seen_req = 1'b0; seen_done = 1'b0;
            @(negedge clk);
            req_valid = 1'b1; req_is_store = 1'b0; funct3 = 3'b010; addr = 32'h8000_0400;
            for (int cyc = 0; cyc < 40; cyc++) begin
                #1;
                if (done) begin
                    seen_done = 1'b1;
                    chk_val("tmo_fault", {30'd0, fault, misalign}, 32'd2);
                    break;
                end
                if (bus_req_valid) seen_req = 1'b1;
                if (seen_req) since_req++;
                bus_req_ready = bus_req_valid;
                @(negedge clk);
            end
            chk_val("tmo_done_seen", 32'(seen_done), 32'd1);
            chk_val("tmo_latency", 32'(since_req), 32'd8);
            req_valid = 1'b0; bus_req_ready = 1'b0;
            @(negedge clk);
            bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h2222_2222;
            #1;
            chk_val("tmo_late_rsp", {29'd0, done, stall, bus_req_valid}, 32'd0);
            @(negedge clk);
            bus_rsp_valid = 1'b0;
            #1;
            chk_val("tmo_late_rsp2", {30'd0, done, fault}, 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
